instr_mem_loader: RTL and testbench

Loads a program into the instruction memory from an 8-bit byte stream (e.g. a UART receiver), before or between runs of the pipeline. It is the write side of the instruction memory that the fetch stage reads. While it loads, it holds the fetch stage. When the load completes, it pulses a PC restart so execution begins at word address 0.

---
 rtl/instr_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: parses a 16-bit word count, assembles little-endian
// words and writes them to instruction memory while holding the fetch stage.
module instr_mem_loader #(
    parameter int width_B = 32,
    parameter int Addr_B  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               mem_we,
    output logic [Addr_B-1:0]  mem_addr,
    output logic [width_B-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               pc_restart,
    output logic               done,
    output logic               error
);

    localparam int lanes = width_B / 8;
    localparam int idx_w = (lanes > 1) ? $clog2(lanes) : 1;
    localparam logic [16:0] max_words = 17'(2 ** Addr_B);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_reg;
    logic              rx_ready_reg;
    logic              mem_we_reg;
    logic              cpu_hold_reg;
    logic              pc_restart_reg;
    logic              done_reg;
    logic              error_reg;
    logic [7:0]        len_lo_reg;
    logic [Addr_B-1:0] addr_reg;
    logic [Addr_B-1:0] last_addr_reg;
    logic [idx_w-1:0]  byte_idx_reg;

    logic        xfer;
    logic        lane_load;
    logic [15:0] n_words;
    logic        n_bad;

    assign xfer      = rx_valid && rx_ready_reg;
    assign lane_load = xfer && (state_reg == S_DATA);
    assign n_words   = {rx_data, len_lo_reg};
    // Full 16-bit compare; N equal to the memory depth is still legal.
    assign n_bad     = (n_words == 16'd0) || ({1'b0, n_words} > max_words);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            rx_ready_reg   <= 1'b0;
            mem_we_reg     <= 1'b0;
            cpu_hold_reg   <= 1'b0;
            pc_restart_reg <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            len_lo_reg     <= '0;
            addr_reg       <= '0;
            last_addr_reg  <= '0;
            byte_idx_reg   <= '0;
        end else begin
            mem_we_reg     <= 1'b0;
            pc_restart_reg <= 1'b0;
            done_reg       <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_LEN_LO;
                        rx_ready_reg <= 1'b1;
                        cpu_hold_reg <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo_reg <= rx_data;
                        state_reg  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        if (n_bad) begin
                            state_reg    <= S_ERR;
                            rx_ready_reg <= 1'b0;
                            error_reg    <= 1'b1;
                        end else begin
                            state_reg     <= S_DATA;
                            addr_reg      <= '0;
                            byte_idx_reg  <= '0;
                            // Store N-1 so the address counter never needs to reach N.
                            last_addr_reg <= Addr_B'(n_words - 16'd1);
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx_reg <= byte_idx_reg + idx_w'(1);
                        if (byte_idx_reg == idx_w'(lanes - 1)) begin
                            state_reg    <= S_WRITE;
                            rx_ready_reg <= 1'b0;
                            mem_we_reg   <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (addr_reg == last_addr_reg) begin
                        state_reg      <= S_DONE;
                        done_reg       <= 1'b1;
                        pc_restart_reg <= 1'b1;
                    end else begin
                        state_reg    <= S_DATA;
                        addr_reg     <= addr_reg + Addr_B'(1);
                        byte_idx_reg <= '0;
                        rx_ready_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg    <= S_IDLE;
                    cpu_hold_reg <= 1'b0;
                end
                S_ERR: begin
                    if (start) begin
                        state_reg    <= S_LEN_LO;
                        error_reg    <= 1'b0;
                        rx_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    rx_ready_reg <= 1'b0;
                    cpu_hold_reg <= 1'b0;
                end
            endcase
        end
    end

    // One register per byte lane; the assembled word is held through the write cycle.
    genvar gi;
    generate
        for (gi = 0; gi < lanes; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (lane_load && (byte_idx_reg == idx_w'(gi))) begin
                    lane_reg <= rx_data;
                end
            end
            assign mem_wdata[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    assign rx_ready   = rx_ready_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = addr_reg;
    assign cpu_hold   = cpu_hold_reg;
    assign pc_restart = pc_restart_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: streams programs with random gaps and
// compares the observed write sequence and memory image against expected programs.
module tb_instr_mem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          pc_restart;
    logic          done;
    logic          error;

    instr_mem_loader #(.width_B(32), .Addr_B(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .pc_restart (pc_restart),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory image as written by the DUT, and the image the programs imply.
    logic [31:0] dut_mem [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] wr_data_q [$];
    int          wr_addr_q [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_wr_cyc = 0;
    logic        after_done = 1'b0;
    logic [31:0] words_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            dut_mem[mem_addr] = mem_wdata;
            last_wr_cyc = cyc;
            chk("hold_in_write", cpu_hold, 1);
        end
        if (done || pc_restart) begin
            chk("restart_with_done", pc_restart, done);
            done_cnt++;
            done_cyc = cyc;
        end
        if (after_done) chk("hold_after_done", cpu_hold, 0);
        after_done = done;
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_hold", cpu_hold, 1);
        chk("start_ready", rx_ready, 1);
        chk("start_err_clr", error, 0);
    endtask

    // Sends each byte, keeping it on the bus until accepted; garbage during gaps.
    task automatic send_bytes(input logic [7:0] s[$], input int gap_max);
        int g;
        int k;
        foreach (s[i]) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = s[i];
            for (k = 0; k < 64; k++) begin
                if (rx_ready) break;
                @(negedge clk);
            end
            if (k == 64) begin
                chk("rx_ready_timeout", 0, 1);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic build_stream(input logic [31:0] w[$], output logic [7:0] s[$]);
        int n;
        n = w.size();
        s.delete();
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        foreach (w[i])
            for (int b = 0; b < 4; b++) s.push_back(w[i][8*b +: 8]);
    endtask

    task automatic load_words(input logic [31:0] w[$], input int gap_max, input int glitch);
        logic [7:0] s[$];
        int n;
        n = w.size();
        build_stream(w, s);
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        do_start();
        fork
            send_bytes(s, gap_max);
            begin
                if (glitch > 0) begin
                    repeat (glitch) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        for (int k = 0; k < 30 && done_cnt == 0; k++) @(negedge clk);
        @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("done_after_write", done_cyc, last_wr_cyc + 1);
        chk("write_count", wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            chk("write_addr", wr_addr_q[i], i);
            chk("write_data", wr_data_q[i], w[i]);
            exp_mem[i] = w[i];
        end
        chk("idle_hold", cpu_hold, 0);
        $display("load N=%0d gap=%0d glitch=%0d writes=%0d", n, gap_max, glitch, wr_addr_q.size());
    endtask

    task automatic bad_header(input logic [7:0] lo, input logic [7:0] hi);
        logic [7:0] s[$];
        s.delete();
        s.push_back(lo);
        s.push_back(hi);
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        send_bytes(s, 1);
        chk("err_set", error, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", error, 1);
        chk("err_hold", cpu_hold, 1);
        chk("err_ready", rx_ready, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (4) @(negedge clk);
        chk("err_ignore_rx", rx_ready, 0);
        rx_valid = 1'b0;
        chk("err_no_write", wr_addr_q.size(), 0);
        $display("bad header %02h %02h error=%0b", lo, hi, error);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        int mism;
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = 32'h0;
            exp_mem[i] = 32'h0;
        end
        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", rx_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_restart", pc_restart, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;

        // Bytes offered in IDLE are not consumed.
        rx_valid = 1'b1;
        rx_data = 8'h55;
        repeat (3) @(negedge clk);
        chk("idle_ready", rx_ready, 0);
        chk("idle_hold0", cpu_hold, 0);
        rx_valid = 1'b0;

        words_q.delete();
        words_q.push_back(32'h12345678);
        load_words(words_q, 0, 0);

        words_q.delete();
        words_q.push_back(32'h00000001);
        words_q.push_back(32'h8C010004);
        words_q.push_back(32'hFFFFFFFF);
        load_words(words_q, 3, 0);

        bad_header(8'h00, 8'h00);
        words_q.delete();
        repeat (2) words_q.push_back($urandom);
        load_words(words_q, 2, 0);

        bad_header(8'h01, 8'h04);
        words_q.delete();
        repeat (3) words_q.push_back($urandom);
        load_words(words_q, 1, 0);

        words_q.delete();
        for (int i = 0; i < DEPTH; i++) words_q.push_back(32'hA5000000 + 32'(i));
        load_words(words_q, 0, 0);

        // Reset after two data bytes of word 5.
        words_q.delete();
        repeat (8) words_q.push_back($urandom);
        build_stream(words_q, s);
        s = s[0:23];
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        send_bytes(s, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_ready", rx_ready, 0);
        chk("mid_we", mem_we, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_wdata", mem_wdata, 0);
        chk("mid_hold", cpu_hold, 0);
        chk("mid_restart", pc_restart, 0);
        chk("mid_done", done, 0);
        chk("mid_error", error, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_write_count", wr_addr_q.size(), 5);
        for (int i = 0; i < 5; i++) exp_mem[i] = words_q[i];
        for (int i = 0; i < 8; i++) chk("mid_mem", dut_mem[i], exp_mem[i]);
        $display("reset mid-word writes=%0d", wr_addr_q.size());

        words_q.delete();
        repeat (6) words_q.push_back($urandom);
        load_words(words_q, 1, 12);

        for (int t = 0; t < 6; t++) begin
            words_q.delete();
            repeat ($urandom_range(16, 1)) words_q.push_back($urandom);
            load_words(words_q, int'($urandom_range(4, 0)), (t % 2 == 1) ? int'($urandom_range(30, 5)) : 0);
        end

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== exp_mem[i]) mism++;
        chk("final_mem_image", mism, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
